// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite to SRAM bridge: response codes and bridge FSM states.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        R_RESP,
        B_RESP
    } bridge_state_e;

endpackage

// File: rtl/axi_lite_mem_bridge_v2_if.sv
// AXI4-Lite channel bundle; port suffixes are named from the slave (bridge) side.
interface axi_lite_mem_bridge_v2_if #(
    parameter int unsigned AXI_AW = 16,
    parameter int unsigned AXI_DW = 32
);
    logic [AXI_AW-1:0]   aw_addr_i;
    logic                aw_valid_i;
    logic                aw_ready_o;
    logic [AXI_DW-1:0]   w_data_i;
    logic [AXI_DW/8-1:0] w_strb_i;
    logic                w_valid_i;
    logic                w_ready_o;
    logic [1:0]          b_resp_o;
    logic                b_valid_o;
    logic                b_ready_i;
    logic [AXI_AW-1:0]   ar_addr_i;
    logic                ar_valid_i;
    logic                ar_ready_o;
    logic [AXI_DW-1:0]   r_data_o;
    logic [1:0]          r_resp_o;
    logic                r_valid_o;
    logic                r_ready_i;

    modport slave (
        input  aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
               ar_addr_i, ar_valid_i, r_ready_i,
        output aw_ready_o, w_ready_o, b_resp_o, b_valid_o, ar_ready_o,
               r_data_o, r_resp_o, r_valid_o
    );

    modport master (
        output aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
               ar_addr_i, ar_valid_i, r_ready_i,
        input  aw_ready_o, w_ready_o, b_resp_o, b_valid_o, ar_ready_o,
               r_data_o, r_resp_o, r_valid_o
    );
endinterface

// File: rtl/axi_lite_hold_reg.sv
// One-entry valid/ready holding register; the consumer empties it with pop_i.
module axi_lite_hold_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (valid_i && !full_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign ready_o = !full_q;
    assign full_o  = full_q;
    assign data_o  = data_q;
endmodule

// File: rtl/axi_lite_mem_bridge_v2.sv
// AXI4-Lite slave to single-port SRAM bridge with fair read/write alternation,
// registered read data and DECERR bypass for out-of-range addresses.
//
// state   | meaning
// IDLE    | arbitrate held requests; issue memory access or error bypass
// RD_WAIT | count down read latency; capture rdata_i when the count is 1
// R_RESP  | present R beat until r_ready_i
// B_RESP  | present B beat until b_ready_i
module axi_lite_mem_bridge_v2
    import axi_lite_pkg::*;
#(
    parameter int unsigned       AXI_AW     = 16,
    parameter int unsigned       AXI_DW     = 32,
    parameter int unsigned       MEM_AW     = 16,
    parameter int unsigned       MEM_DW     = 32,
    parameter logic [MEM_AW-1:0] ADDR_MASK  = '0,
    parameter int unsigned       MEM_BYTES  = 32'h10000,
    parameter int unsigned       RD_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    axi_lite_mem_bridge_v2_if.slave axi,
    output logic                    req_o,
    output logic                    we_o,
    output logic [MEM_AW-1:0]       addr_o,
    output logic [MEM_DW-1:0]       wdata_o,
    output logic [MEM_DW/8-1:0]     be_o,
    input  logic [MEM_DW-1:0]       rdata_i
);
    if (AXI_DW != MEM_DW) begin : g_chk_dw
        $error("axi_lite_mem_bridge_v2: AXI_DW must equal MEM_DW");
    end
    if (MEM_AW < AXI_AW) begin : g_chk_aw
        $error("axi_lite_mem_bridge_v2: MEM_AW must be >= AXI_AW");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_chk_lat
        $error("axi_lite_mem_bridge_v2: RD_LATENCY must be 1..4");
    end

    localparam int unsigned       OFF_BITS = $clog2(MEM_DW / 8);
    localparam logic [MEM_AW-1:0] OFF_MASK = MEM_AW'((1 << OFF_BITS) - 1);
    localparam logic [MEM_AW:0]   MEM_LIM  = (MEM_AW + 1)'(MEM_BYTES);

    logic                aw_full, w_full, ar_full, wr_grant, rd_grant;
    logic [AXI_AW-1:0]   aw_addr, ar_addr;
    logic [AXI_DW-1:0]   w_data;
    logic [AXI_DW/8-1:0] w_strb;
    logic [AXI_DW+AXI_DW/8-1:0] w_hold;
    logic [MEM_AW-1:0]   aw_mem, ar_mem;
    logic                aw_in_range, ar_in_range;

    axi_lite_hold_reg #(.WIDTH(AXI_AW)) u_aw_hold (
        .clk_i, .rst_ni, .valid_i(axi.aw_valid_i), .ready_o(axi.aw_ready_o),
        .data_i(axi.aw_addr_i), .pop_i(wr_grant), .full_o(aw_full), .data_o(aw_addr)
    );
    axi_lite_hold_reg #(.WIDTH(AXI_DW + AXI_DW/8)) u_w_hold (
        .clk_i, .rst_ni, .valid_i(axi.w_valid_i), .ready_o(axi.w_ready_o),
        .data_i({axi.w_strb_i, axi.w_data_i}), .pop_i(wr_grant), .full_o(w_full), .data_o(w_hold)
    );
    axi_lite_hold_reg #(.WIDTH(AXI_AW)) u_ar_hold (
        .clk_i, .rst_ni, .valid_i(axi.ar_valid_i), .ready_o(axi.ar_ready_o),
        .data_i(axi.ar_addr_i), .pop_i(rd_grant), .full_o(ar_full), .data_o(ar_addr)
    );

    assign {w_strb, w_data} = w_hold;

    // Range check uses the masked, word-aligned address actually driven to memory.
    assign aw_mem      = (MEM_AW'(aw_addr) & ~ADDR_MASK) & ~OFF_MASK;
    assign ar_mem      = (MEM_AW'(ar_addr) & ~ADDR_MASK) & ~OFF_MASK;
    assign aw_in_range = {1'b0, aw_mem} < MEM_LIM;
    assign ar_in_range = {1'b0, ar_mem} < MEM_LIM;

    bridge_state_e     state_q, state_d;
    logic              last_wr_q, last_wr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [AXI_DW-1:0] r_data_q, r_data_d;
    resp_e             r_resp_q, r_resp_d, b_resp_q, b_resp_d;

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        cnt_d     = cnt_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        b_resp_d  = b_resp_q;
        wr_grant  = 1'b0;
        rd_grant  = 1'b0;
        req_o     = 1'b0;
        we_o      = 1'b0;
        addr_o    = '0;
        wdata_o   = '0;
        be_o      = '0;
        unique case (state_q)
            IDLE: begin
                // last_wr only moves on contended grants, so lone grants never skew fairness.
                if (aw_full && w_full && ar_full) begin
                    rd_grant  = last_wr_q;
                    wr_grant  = !last_wr_q;
                    last_wr_d = !last_wr_q;
                end else begin
                    wr_grant = aw_full && w_full;
                    rd_grant = ar_full;
                end
                if (wr_grant) begin
                    state_d  = B_RESP;
                    b_resp_d = aw_in_range ? OKAY : DECERR;
                    if (aw_in_range && w_strb != '0) begin
                        req_o   = 1'b1;
                        we_o    = 1'b1;
                        addr_o  = aw_mem;
                        wdata_o = w_data;
                        be_o    = w_strb;
                    end
                end else if (rd_grant) begin
                    if (ar_in_range) begin
                        req_o    = 1'b1;
                        addr_o   = ar_mem;
                        cnt_d    = 3'(RD_LATENCY);
                        r_resp_d = OKAY;
                        state_d  = RD_WAIT;
                    end else begin
                        r_data_d = '0;
                        r_resp_d = DECERR;
                        state_d  = R_RESP;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 3'd1) begin
                    r_data_d = rdata_i;
                    state_d  = R_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            R_RESP: begin
                if (axi.r_ready_i) state_d = IDLE;
            end
            B_RESP: begin
                if (axi.b_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b1;
            cnt_q     <= '0;
            r_data_q  <= '0;
            r_resp_q  <= OKAY;
            b_resp_q  <= OKAY;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            cnt_q     <= cnt_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            b_resp_q  <= b_resp_d;
        end
    end

    assign axi.b_valid_o = (state_q == B_RESP);
    assign axi.b_resp_o  = b_resp_q;
    assign axi.r_valid_o = (state_q == R_RESP);
    assign axi.r_data_o  = r_data_q;
    assign axi.r_resp_o  = r_resp_q;
endmodule

// File: tb/tb_axi_lite_mem_bridge_v2.sv
// Bench for axi_lite_mem_bridge_v2: SRAM model with 2-cycle read latency, scoreboard queues
// for memory requests, B and R beats, a vector table and directed multi-cycle sequences.
module tb_axi_lite_mem_bridge_v2;
    logic        clk;
    logic        rst_n;
    logic        req_o, we_o;
    logic [15:0] addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic [31:0] rdata_i;

    axi_lite_mem_bridge_v2_if #(.AXI_AW(16), .AXI_DW(32)) bus ();

    axi_lite_mem_bridge_v2 #(
        .AXI_AW(16), .AXI_DW(32), .MEM_AW(16), .MEM_DW(32),
        .ADDR_MASK(16'h8000), .MEM_BYTES(32'h1000), .RD_LATENCY(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .axi(bus),
        .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .be_o(be_o), .rdata_i(rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  resp;
        bit          acc;
    } vec_t;

    mem_exp_t   exp_mem[$];
    r_exp_t     exp_r[$];
    logic [1:0] exp_b[$];
    logic [31:0] ref_mem [0:1023];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SRAM model: write on req_o&we_o, read data valid two cycles after req_o, noise otherwise.
    logic [31:0] sram [0:1023];
    bit          sram_init;
    logic        rd_v_s1;
    logic [9:0]  rd_idx_s1;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 1024; i++) sram[i] <= 32'hA500_0000 | 32'(i);
            sram_init <= 1'b1;
        end else if (req_o && we_o) begin
            for (int i = 0; i < 4; i++)
                if (be_o[i]) sram[addr_o[11:2]][8*i +: 8] <= wdata_o[8*i +: 8];
        end
        rd_v_s1   <= req_o && !we_o;
        rd_idx_s1 <= addr_o[11:2];
        rdata_i   <= rd_v_s1 ? sram[rd_idx_s1] : $urandom;
    end

    logic        prev_rv, prev_rr, prev_bv, prev_br;
    logic [33:0] prev_r;
    logic [1:0]  prev_b;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv = 1'b0;
            prev_bv = 1'b0;
        end else begin
            if (req_o) begin
                if (exp_mem.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_unexpected: got req_o=1 addr 0x%0h, expected no request", addr_o);
                end else begin
                    chk("mem_req", 64'(exp_mem.pop_front()), 64'({we_o, addr_o, wdata_o, be_o}));
                end
            end else begin
                chk("mem_idle_zero", 64'({we_o, addr_o, wdata_o, be_o}), 64'd0);
            end
            if (prev_rv && !prev_rr) begin
                chk("r_hold_valid", 64'(bus.r_valid_o), 64'd1);
                chk("r_hold_beat", 64'({bus.r_data_o, bus.r_resp_o}), 64'(prev_r));
            end
            if (prev_bv && !prev_br) begin
                chk("b_hold_valid", 64'(bus.b_valid_o), 64'd1);
                chk("b_hold_resp", 64'(bus.b_resp_o), 64'(prev_b));
            end
            if (bus.r_valid_o && bus.r_ready_i) begin
                if (exp_r.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_unexpected: got R beat 0x%0h, expected none", bus.r_data_o);
                end else chk("r_beat", 64'({bus.r_data_o, bus.r_resp_o}), 64'(exp_r.pop_front()));
            end
            if (bus.b_valid_o && bus.b_ready_i) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got B resp %0d, expected none", bus.b_resp_o);
                end else chk("b_resp", 64'(bus.b_resp_o), 64'(exp_b.pop_front()));
            end
            prev_rv = bus.r_valid_o; prev_rr = bus.r_ready_i; prev_r = {bus.r_data_o, bus.r_resp_o};
            prev_bv = bus.b_valid_o; prev_br = bus.b_ready_i; prev_b = bus.b_resp_o;
        end
    end

    task automatic expect_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                                input logic [1:0] resp, input bit acc);
        logic [15:0] ma;
        ma = a & 16'h7FFC;
        if (acc) begin
            exp_mem.push_back(mem_exp_t'({1'b1, ma, d, s}));
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_mem[ma[11:2]][8*i +: 8] = d[8*i +: 8];
        end
        exp_b.push_back(resp);
    endtask

    task automatic expect_read(input logic [15:0] a, input logic [1:0] resp, input bit acc);
        logic [15:0] ma;
        ma = a & 16'h7FFC;
        if (acc) begin
            exp_mem.push_back(mem_exp_t'({1'b0, ma, 32'h0, 4'h0}));
            exp_r.push_back(r_exp_t'({ref_mem[ma[11:2]], resp}));
        end else begin
            exp_r.push_back(r_exp_t'({32'h0, resp}));
        end
    endtask

    task automatic send(input bit do_aw, input logic [15:0] awa, input bit do_w, input logic [31:0] wd,
                        input logic [3:0] ws, input bit do_ar, input logic [15:0] ara);
        bit pa, pw, pr, ha, hw, hr;
        int n;
        pa = do_aw; pw = do_w; pr = do_ar; n = 0;
        if (do_aw) begin bus.aw_addr_i = awa; bus.aw_valid_i = 1'b1; end
        if (do_w)  begin bus.w_data_i = wd; bus.w_strb_i = ws; bus.w_valid_i = 1'b1; end
        if (do_ar) begin bus.ar_addr_i = ara; bus.ar_valid_i = 1'b1; end
        while ((pa || pw || pr) && n < 100) begin
            ha = pa && bus.aw_ready_o;
            hw = pw && bus.w_ready_o;
            hr = pr && bus.ar_ready_o;
            @(posedge clk); #1; n++;
            if (ha) begin bus.aw_valid_i = 1'b0; pa = 1'b0; end
            if (hw) begin bus.w_valid_i = 1'b0; pw = 1'b0; end
            if (hr) begin bus.ar_valid_i = 1'b0; pr = 1'b0; end
        end
        chk("handshake_bound", 64'(n >= 100), 64'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_mem.size() + exp_r.size() + exp_b.size()) != 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", 64'(exp_mem.size() + exp_r.size() + exp_b.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mem"}, 64'({req_o, we_o, addr_o, wdata_o, be_o}), 64'd0);
        chk({tag, "_ready"}, 64'({bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o}), 64'd7);
        chk({tag, "_b"}, 64'({bus.b_valid_o, bus.b_resp_o}), 64'd0);
        chk({tag, "_r"}, 64'({bus.r_valid_o, bus.r_resp_o, bus.r_data_o}), 64'd0);
    endtask

    vec_t vecs [13];
    int   n, rv_cnt;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
        vecs[0]  = '{1'b1, 16'h0100, 32'h1111_2222, 4'hF, 2'b00, 1'b1};
        vecs[1]  = '{1'b0, 16'h0100, 32'h0,         4'h0, 2'b00, 1'b1};
        vecs[2]  = '{1'b1, 16'h0104, 32'hAABB_CCDD, 4'h5, 2'b00, 1'b1};
        vecs[3]  = '{1'b0, 16'h0104, 32'h0,         4'h0, 2'b00, 1'b1};
        vecs[4]  = '{1'b1, 16'h0108, 32'hFFFF_FFFF, 4'h0, 2'b00, 1'b0};
        vecs[5]  = '{1'b0, 16'h0108, 32'h0,         4'h0, 2'b00, 1'b1};
        vecs[6]  = '{1'b1, 16'h8200, 32'hCAFE_F00D, 4'hF, 2'b00, 1'b1};
        vecs[7]  = '{1'b0, 16'h0200, 32'h0,         4'h0, 2'b00, 1'b1};
        vecs[8]  = '{1'b1, 16'h0FFE, 32'h0BAD_CAFE, 4'hF, 2'b00, 1'b1};
        vecs[9]  = '{1'b0, 16'h0FFC, 32'h0,         4'h0, 2'b00, 1'b1};
        vecs[10] = '{1'b0, 16'h1000, 32'h0,         4'h0, 2'b11, 1'b0};
        vecs[11] = '{1'b1, 16'h1000, 32'h0101_0101, 4'hF, 2'b11, 1'b0};
        vecs[12] = '{1'b0, 16'h9004, 32'h0,         4'h0, 2'b11, 1'b0};

        rst_n = 1'b0;
        bus.aw_addr_i = '0; bus.aw_valid_i = 1'b0;
        bus.w_data_i = '0; bus.w_strb_i = '0; bus.w_valid_i = 1'b0;
        bus.ar_addr_i = '0; bus.ar_valid_i = 1'b0;
        bus.b_ready_i = 1'b1; bus.r_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Contention twice: read wins the first round, write the second.
        expect_read(16'h0040, 2'b00, 1'b1);
        expect_write(16'h0044, 32'h0102_0304, 4'hF, 2'b00, 1'b1);
        send(1'b1, 16'h0044, 1'b1, 32'h0102_0304, 4'hF, 1'b1, 16'h0040);
        wait_idle();
        expect_write(16'h0048, 32'h0A0B_0C0D, 4'hF, 2'b00, 1'b1);
        expect_read(16'h004C, 2'b00, 1'b1);
        send(1'b1, 16'h0048, 1'b1, 32'h0A0B_0C0D, 4'hF, 1'b1, 16'h004C);
        wait_idle();

        // AW+W together, then read back.
        expect_write(16'h0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 1'b1);
        send(1'b1, 16'h0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 16'h0);
        chk("t1_wr_req_latency", 64'({req_o, we_o}), 64'd3);
        @(posedge clk); #1;
        chk("t1_b_latency", 64'(bus.b_valid_o), 64'd1);
        wait_idle();
        expect_read(16'h0010, 2'b00, 1'b1);
        send(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1, 16'h0010);
        chk("t1_rd_req_latency", 64'({req_o, we_o}), 64'd2);
        wait_idle();

        // W three cycles ahead of AW.
        expect_write(16'h0020, 32'h1234_5678, 4'h3, 2'b00, 1'b1);
        send(1'b0, 16'h0, 1'b1, 32'h1234_5678, 4'h3, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_w_held", 64'({bus.w_ready_o, req_o}), 64'd0);
            @(posedge clk); #1;
        end
        send(1'b1, 16'h0020, 1'b0, 32'h0, 4'h0, 1'b0, 16'h0);
        wait_idle();

        // Out-of-range read and write: no memory access, DECERR, zero read data.
        expect_read(16'hFFFC, 2'b11, 1'b0);
        expect_write(16'h2000, 32'h5555_5555, 4'hF, 2'b11, 1'b0);
        send(1'b1, 16'h2000, 1'b1, 32'h5555_5555, 4'hF, 1'b1, 16'hFFFC);
        wait_idle();

        // R backpressure while rdata_i toggles.
        bus.r_ready_i = 1'b0;
        expect_read(16'h0010, 2'b00, 1'b1);
        send(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1, 16'h0010);
        n = 0;
        while (!bus.r_valid_o && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            chk("t5_r_stall", 64'({bus.r_valid_o, bus.r_data_o}), 64'({1'b1, 32'hDEAD_BEEF}));
            @(posedge clk); #1;
        end
        bus.r_ready_i = 1'b1;
        wait_idle();

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                expect_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].resp, vecs[i].acc);
                send(1'b1, vecs[i].addr, 1'b1, vecs[i].wdata, vecs[i].strb, 1'b0, 16'h0);
            end else begin
                expect_read(vecs[i].addr, vecs[i].resp, vecs[i].acc);
                send(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1, vecs[i].addr);
            end
            wait_idle();
        end

        // Reset during RD_WAIT drops the read; a fresh read then completes.
        exp_mem.push_back(mem_exp_t'({1'b0, 16'h0300, 32'h0, 4'h0}));
        send(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1, 16'h0300);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset("t6_reset");
        rst_n = 1'b1;
        rv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.r_valid_o) rv_cnt++;
        end
        chk("t6_no_r_after_reset", 64'(rv_cnt), 64'd0);
        expect_read(16'h0300, 2'b00, 1'b1);
        send(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1, 16'h0300);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
